// File: rtl/hvac_cmd_sequencer.sv
// Command sequencer feeding HVAC_Control: debounced power buttons, hysteretic
// temperature decisions and a minimum-dwell guard between mode commands.
module hvac_cmd_sequencer #(
    parameter int TEMP_W     = 8,
    parameter int DEB_CYCLES = 4,
    parameter int HYST       = 2,
    parameter int MIN_DWELL  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_on,
    input  logic              btn_off,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              cmd_on,
    output logic              cmd_heat,
    output logic              cmd_cool,
    output logic              cmd_off,
    output logic [1:0]        mode
);

    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam int DW_W  = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);

    localparam int C_ON   = 0;
    localparam int C_HEAT = 1;
    localparam int C_COOL = 2;
    localparam int C_OFF  = 3;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_IDLE = 2'b01,
        ST_HEAT = 2'b10,
        ST_COOL = 2'b11
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        cmd_reg;
    logic [3:0]        cmd_next;
    logic [DW_W-1:0]   dwell_reg;
    logic [TEMP_W-1:0] temp_q_reg;
    logic              have_temp_reg;

    logic [1:0]        btn_raw;
    logic [1:0]        btn_evt;
    logic              on_evt;
    logic              off_evt;

    assign btn_raw = {btn_off, btn_on};

    // Bit 0 is the power-on button, bit 1 the power-off button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             lvl_reg;
            logic             evt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                    lvl_reg <= 1'b0;
                    evt_reg <= 1'b0;
                end else begin
                    evt_reg <= 1'b0;
                    if (btn_raw[gi] != lvl_reg) begin
                        if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                            lvl_reg <= btn_raw[gi];
                            cnt_reg <= '0;
                            evt_reg <= btn_raw[gi];
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign btn_evt[gi] = evt_reg;
        end
    endgenerate

    assign on_evt  = btn_evt[0];
    assign off_evt = btn_evt[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_q_reg    <= '0;
            have_temp_reg <= 1'b0;
        end else if (temp_valid) begin
            temp_q_reg    <= temp;
            have_temp_reg <= 1'b1;
        end
    end

    // One extra bit so temp_q + HYST and setpoint + HYST never wrap.
    logic [TEMP_W:0] temp_ext;
    logic [TEMP_W:0] sp_ext;
    logic [TEMP_W:0] hyst_ext;
    logic            cold;
    logic            hot;
    logic            dwell_zero;

    assign temp_ext   = {1'b0, temp_q_reg};
    assign sp_ext     = {1'b0, setpoint};
    assign hyst_ext   = (TEMP_W + 1)'(HYST);
    assign cold       = (temp_ext + hyst_ext) < sp_ext;
    assign hot        = temp_ext > (sp_ext + hyst_ext);
    assign dwell_zero = (dwell_reg == '0);

    always_comb begin
        state_next = state_reg;
        cmd_next   = '0;
        case (state_reg)
            ST_OFF: begin
                if (on_evt && !off_evt) begin
                    cmd_next[C_ON] = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (off_evt) begin
                    cmd_next[C_OFF] = 1'b1;
                    state_next      = ST_OFF;
                end else if (dwell_zero && have_temp_reg) begin
                    if (cold) begin
                        cmd_next[C_HEAT] = 1'b1;
                        state_next       = ST_HEAT;
                    end else if (hot) begin
                        cmd_next[C_COOL] = 1'b1;
                        state_next       = ST_COOL;
                    end
                end
            end
            ST_HEAT: begin
                if (off_evt) begin
                    cmd_next[C_OFF] = 1'b1;
                    state_next      = ST_OFF;
                end else if (dwell_zero && hot) begin
                    cmd_next[C_COOL] = 1'b1;
                    state_next       = ST_COOL;
                end
            end
            ST_COOL: begin
                if (off_evt) begin
                    cmd_next[C_OFF] = 1'b1;
                    state_next      = ST_OFF;
                end else if (dwell_zero && cold) begin
                    cmd_next[C_HEAT] = 1'b1;
                    state_next       = ST_HEAT;
                end
            end
        endcase
    end

    // Any issued command restarts the dwell window, including cmd_on/cmd_off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_OFF;
            cmd_reg   <= '0;
            dwell_reg <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            if (|cmd_next) begin
                dwell_reg <= DW_W'(MIN_DWELL);
            end else if (!dwell_zero) begin
                dwell_reg <= dwell_reg - DW_W'(1);
            end
        end
    end

    assign cmd_on   = cmd_reg[C_ON];
    assign cmd_heat = cmd_reg[C_HEAT];
    assign cmd_cool = cmd_reg[C_COOL];
    assign cmd_off  = cmd_reg[C_OFF];
    assign mode     = state_reg;

endmodule

// File: tb/tb_hvac_cmd_sequencer.sv
// Self-checking bench for hvac_cmd_sequencer: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_hvac_cmd_sequencer;

    localparam int TEMP_W     = 8;
    localparam int DEB_CYCLES = 4;
    localparam int HYST       = 2;
    localparam int MIN_DWELL  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_on = 1'b0;
    logic              btn_off = 1'b0;
    logic              temp_valid = 1'b0;
    logic [TEMP_W-1:0] temp = '0;
    logic [TEMP_W-1:0] setpoint = '0;
    logic              cmd_on, cmd_heat, cmd_cool, cmd_off;
    logic [1:0]        mode;
    logic [3:0]        cmds;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mark = 0;

    assign cmds = {cmd_off, cmd_cool, cmd_heat, cmd_on};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hvac_cmd_sequencer #(
        .TEMP_W(TEMP_W), .DEB_CYCLES(DEB_CYCLES), .HYST(HYST), .MIN_DWELL(MIN_DWELL)
    ) dut (
        .clk(clk), .reset(reset), .btn_on(btn_on), .btn_off(btn_off),
        .temp_valid(temp_valid), .temp(temp), .setpoint(setpoint),
        .cmd_on(cmd_on), .cmd_heat(cmd_heat), .cmd_cool(cmd_cool), .cmd_off(cmd_off),
        .mode(mode)
    );

    // Behavioural model: mode 0 OFF, 1 IDLE, 2 HEAT, 3 COOL; exp_cmd = {off,cool,heat,on}.
    int         m_state, m_dwell, m_tq, m_have;
    int         m_lvl [2];
    int         m_streak [2];
    int         m_evt [2];
    logic [3:0] exp_cmd;

    function automatic void model_step();
        int         sp;
        int         raw;
        int         ns;
        bit         cold;
        bit         hot;
        logic [3:0] nc;
        sp   = int'(setpoint);
        cold = (m_tq + HYST) < sp;
        hot  = m_tq > (sp + HYST);
        nc   = 4'b0000;
        ns   = m_state;
        if (m_state == 0) begin
            if (m_evt[0] != 0 && m_evt[1] == 0) begin nc = 4'b0001; ns = 1; end
        end else if (m_evt[1] != 0) begin
            nc = 4'b1000; ns = 0;
        end else if (m_dwell == 0) begin
            if (m_state == 1 && m_have != 0 && cold)     begin nc = 4'b0010; ns = 2; end
            else if (m_state == 1 && m_have != 0 && hot) begin nc = 4'b0100; ns = 3; end
            else if (m_state == 2 && hot)                begin nc = 4'b0100; ns = 3; end
            else if (m_state == 3 && cold)               begin nc = 4'b0010; ns = 2; end
        end
        if (nc != 4'b0000) m_dwell = MIN_DWELL;
        else if (m_dwell > 0) m_dwell = m_dwell - 1;
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? int'(btn_on) : int'(btn_off);
            m_evt[b] = 0;
            if (raw != m_lvl[b]) begin
                m_streak[b]++;
                if (m_streak[b] == DEB_CYCLES) begin
                    m_lvl[b]    = raw;
                    m_streak[b] = 0;
                    m_evt[b]    = raw;
                end
            end else begin
                m_streak[b] = 0;
            end
        end
        if (temp_valid) begin m_tq = int'(temp); m_have = 1; end
        m_state = ns;
        exp_cmd = nc;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_dwell = 0; m_tq = 0; m_have = 0; exp_cmd = 4'b0000;
            for (int b = 0; b < 2; b++) begin m_lvl[b] = 0; m_streak[b] = 0; m_evt[b] = 0; end
        end else begin
            model_step();
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmds !== 4'b0000 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmds !== 4'b0000 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
        end
    endtask

    task automatic test_power_on();
        int first;
        first = -1;
        btn_on = 1'b1;
        repeat (3) @(negedge clk);
        btn_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b00) begin
                n_bad++;
                $display("FAIL short_press: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
            end
        end
        btn_on = 1'b1;
        for (int i = 1; i <= 8 && first < 0; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== exp_cmd || mode !== 2'(m_state) || !$onehot0(cmds)) begin
                n_bad++;
                $display("FAIL power_on_trace: cmds=%b mode=%b, required cmds=%b mode=%0d", cmds, mode, exp_cmd, m_state);
            end
            if (cmd_on === 1'b1) begin first = i; mark = cyc; end
        end
        btn_on = 1'b0;
        // Start the heat scenario right after the cmd_on edge.
        setpoint = 8'd22; temp = 8'd18; temp_valid = 1'b1;
        n_cmp++;
        if (first != DEB_CYCLES + 1 || mode !== 2'b01) begin
            n_bad++;
            $display("FAIL cmd_on_latency: edge=%0d mode=%b, required edge=%0d mode=01", first, mode, DEB_CYCLES + 1);
        end
    endtask

    task automatic test_heat();
        int heat_at;
        heat_at = -1;
        for (int i = 0; i < 20 && heat_at < 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                temp_valid = 1'b0;
                n_cmp++;
                if (cmd_on !== 1'b0) begin
                    n_bad++;
                    $display("FAIL cmd_on_width: cmd_on=%b one cycle later, required 0", cmd_on);
                end
            end
            n_cmp++;
            if (cmds !== exp_cmd || mode !== 2'(m_state) || !$onehot0(cmds)) begin
                n_bad++;
                $display("FAIL heat_trace: cmds=%b mode=%b, required cmds=%b mode=%0d", cmds, mode, exp_cmd, m_state);
            end
            if (cmd_heat === 1'b1) heat_at = cyc;
        end
        n_cmp++;
        if (heat_at - mark != MIN_DWELL + 1 || mode !== 2'b10) begin
            n_bad++;
            $display("FAIL heat_latency: edges_after_on=%0d mode=%b, required %0d mode=10", heat_at - mark, mode, MIN_DWELL + 1);
        end
    endtask

    task automatic test_cool();
        int cool_at;
        int latch_at;
        setpoint = 8'd254; temp = 8'd255; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b10) begin
                n_bad++;
                $display("FAIL overflow_no_cool: cmds=%b mode=%b, required cmds=0000 mode=10", cmds, mode);
            end
        end
        temp = 8'd24; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0; setpoint = 8'd22;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b10) begin
                n_bad++;
                $display("FAIL band_edge_hot: cmds=%b mode=%b, required cmds=0000 mode=10", cmds, mode);
            end
        end
        temp = 8'd25; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        latch_at = cyc;
        cool_at = -1;
        for (int i = 0; i < 4 && cool_at < 0; i++) begin
            @(negedge clk);
            if (cmd_cool === 1'b1) cool_at = cyc;
        end
        mark = cool_at;
        n_cmp++;
        if (cool_at != latch_at + 1 || mode !== 2'b11) begin
            n_bad++;
            $display("FAIL cool_decision: edge=%0d mode=%b, required edge=%0d mode=11", cool_at, mode, latch_at + 1);
        end
    endtask

    task automatic test_off();
        int off_at;
        off_at = -1;
        btn_off = 1'b1;
        for (int i = 0; i < 8 && off_at < 0; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== exp_cmd || mode !== 2'(m_state) || !$onehot0(cmds)) begin
                n_bad++;
                $display("FAIL off_trace: cmds=%b mode=%b, required cmds=%b mode=%0d", cmds, mode, exp_cmd, m_state);
            end
            if (cmd_off === 1'b1) off_at = cyc;
        end
        n_cmp++;
        if (off_at != mark + DEB_CYCLES + 1 || mode !== 2'b00 || dut.dwell_reg !== 4'(MIN_DWELL)) begin
            n_bad++;
            $display("FAIL cmd_off_during_dwell: edge=%0d mode=%b dwell=%0d, required edge=%0d mode=00 dwell=%0d",
                     off_at, mode, dut.dwell_reg, mark + DEB_CYCLES + 1, MIN_DWELL);
        end
        btn_off = 1'b0;
        temp = 8'd10; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b00) begin
                n_bad++;
                $display("FAIL off_ignores_temp: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
            end
        end
    endtask

    task automatic test_simultaneous();
        int seen;
        int n_off;
        int n_other;
        btn_on = 1'b1; btn_off = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b00) begin
                n_bad++;
                $display("FAIL both_in_off: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
            end
        end
        btn_on = 1'b0; btn_off = 1'b0;
        repeat (6) @(negedge clk);
        seen = 0;
        btn_on = 1'b1;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (cmd_on === 1'b1) seen = 1;
        end
        btn_on = 1'b0;
        setpoint = 8'd22; temp = 8'd20; temp_valid = 1'b1;
        n_cmp++;
        if (seen == 0 || mode !== 2'b01) begin
            n_bad++;
            $display("FAIL repower_on: seen=%0d mode=%b, required seen=1 mode=01", seen, mode);
        end
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b01) begin
                n_bad++;
                $display("FAIL band_edge_cold: cmds=%b mode=%b, required cmds=0000 mode=01", cmds, mode);
            end
        end
        temp = 8'd26; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            @(negedge clk);
            if (cmd_cool === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen == 0 || mode !== 2'b11) begin
            n_bad++;
            $display("FAIL idle_to_cool: seen=%0d mode=%b, required seen=1 mode=11", seen, mode);
        end
        n_off = 0; n_other = 0;
        btn_on = 1'b1; btn_off = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cmd_off === 1'b1) n_off++;
            if (cmd_on === 1'b1 || cmd_heat === 1'b1 || cmd_cool === 1'b1) n_other++;
        end
        n_cmp++;
        if (n_off != 1 || n_other != 0 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL both_in_cool: off_pulses=%0d other_pulses=%0d mode=%b, required 1 0 mode=00", n_off, n_other, mode);
        end
        btn_on = 1'b0; btn_off = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int seen;
        int first;
        seen = 0;
        btn_on = 1'b1;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (cmd_on === 1'b1) seen = 1;
        end
        btn_on = 1'b0;
        setpoint = 8'd22; temp = 8'd18; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 15 && cmd_heat !== 1'b1; i++) @(negedge clk);
        temp = 8'd25; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 15 && cmd_cool !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (cmd_cool !== 1'b1 || mode !== 2'b11) begin
            n_bad++;
            $display("FAIL reach_cool_pulse: cmd_cool=%b mode=%b, required cmd_cool=1 mode=11", cmd_cool, mode);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (cmds !== 4'b0000 || mode !== 2'b00) begin
            n_bad++;
            $display("FAIL async_reset: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
        end
        @(negedge clk);
        reset = 1'b1;
        temp = 8'd10; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmds !== 4'b0000 || mode !== 2'b00) begin
                n_bad++;
                $display("FAIL post_reset_quiet: cmds=%b mode=%b, required cmds=0000 mode=00", cmds, mode);
            end
        end
        first = -1;
        btn_on = 1'b1;
        for (int i = 1; i <= 8 && first < 0; i++) begin
            @(negedge clk);
            if (cmd_on === 1'b1) first = i;
        end
        btn_on = 1'b0;
        n_cmp++;
        if (first != DEB_CYCLES + 1 || mode !== 2'b01) begin
            n_bad++;
            $display("FAIL post_reset_on: edge=%0d mode=%b, required edge=%0d mode=01", first, mode, DEB_CYCLES + 1);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        int hold_on;
        int hold_off;
        hold_on = 0; hold_off = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_on == 0) begin
                btn_on  = 1'($urandom_range(0, 1));
                hold_on = $urandom_range(1, 8);
            end
            if (hold_off == 0) begin
                btn_off  = ($urandom_range(0, 5) == 0);
                hold_off = $urandom_range(1, 8);
            end
            hold_on--; hold_off--;
            if ($urandom_range(0, 99) == 0) setpoint = TEMP_W'($urandom_range(0, 255));
            temp_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) temp = TEMP_W'($urandom_range(0, 255));
            else temp = TEMP_W'(int'(setpoint) + int'($urandom_range(0, 10)) - 5);
            reset = ($urandom_range(0, 999) != 0);
            @(negedge clk);
            n_cmp++;
            if (cmds !== exp_cmd || mode !== 2'(m_state) || !$onehot0(cmds)) begin
                n_bad++;
                $display("FAIL random_trace cycle %0d: cmds=%b mode=%b, required cmds=%b mode=%0d", c, cmds, mode, exp_cmd, m_state);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        test_reset();
        test_power_on();
        test_heat();
        test_cool();
        test_off();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hvac_cmd_sequencer.md
Name: hvac_cmd_sequencer

Overview:
Upstream command generator for HVAC_Control. It debounces the front-panel on/off buttons and registers temperature samples against a live setpoint with hysteresis. It then issues one-hot, single-cycle command pulses (cmd_on, cmd_heat, cmd_cool, cmd_off) that drive HVAC_Control inputs I1..I4 directly. A minimum-dwell timer enforces compressor protection between mode changes.

Parameters:
TEMP_W, 8, width of temp and setpoint (unsigned)
DEB_CYCLES, 4, consecutive stable cycles required to change a debounced button level (>=1)
HYST, 2, hysteresis band in temperature LSBs
MIN_DWELL, 8, cycles the dwell counter runs after any command pulse before a heat/cool decision is allowed

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
btn_on  input  1  raw power-on button level
btn_off  input  1  raw power-off button level
temp_valid  input  1  temp is valid this cycle
temp  input  TEMP_W  measured temperature, unsigned
setpoint  input  TEMP_W  target temperature, unsigned, sampled live every cycle
cmd_on  output  1  one-cycle pulse to HVAC_Control I1
cmd_heat  output  1  one-cycle pulse to HVAC_Control I2
cmd_cool  output  1  one-cycle pulse to HVAC_Control I3
cmd_off  output  1  one-cycle pulse to HVAC_Control I4
mode  output  2  current state: 00 OFF, 01 IDLE, 10 HEAT, 11 COOL

Behaviour:
- Reset (reset=0):
  - All outputs 0 immediately (asynchronous), mode=00.
  - State OFF; debounced levels 0; debounce counters, dwell counter and have_temp all 0.
  - A pulse in flight is dropped.
  - Release is synchronous to clk.
- Debounce (per button):
  - The counter increments on each edge where raw differs from the debounced level, and clears when they match.
  - The debounced level flips on the edge where the counter would reach DEB_CYCLES.
  - Net effect: raw held for DEB_CYCLES edges flips the level on the DEB_CYCLES-th edge.
  - A debounced rising edge generates a one-cycle event; falling edges are ignored.
- Temperature:
  - temp is latched into temp_q on any edge with temp_valid=1; have_temp is set.
  - temp_q holds between samples.
- Comparisons use TEMP_W+1 bits so there is no wrap:
  - cold = (temp_q + HYST < setpoint)
  - hot = (temp_q > setpoint + HYST)
  - Band edges are non-triggering: temp_q = setpoint ± HYST is neither cold nor hot.
- Dwell:
  - The dwell counter loads MIN_DWELL on every edge that asserts any cmd_* pulse.
  - Otherwise it decrements, saturating at 0.
  - Heat/cool decisions require dwell=0. cmd_off ignores dwell.
- FSM (state and cmd registers update on the same edge; a command pulse is asserted in the cycle after its condition is seen):
  - OFF: on_evt and not off_evt -> cmd_on, go to IDLE.
  - IDLE: off_evt -> cmd_off, go to OFF. Else if dwell=0 and have_temp: cold -> cmd_heat, go to HEAT; hot -> cmd_cool, go to COOL.
  - HEAT: off_evt -> cmd_off, go to OFF. Else if dwell=0 and hot -> cmd_cool, go to COOL.
  - COOL: off_evt -> cmd_off, go to OFF. Else if dwell=0 and cold -> cmd_heat, go to HEAT.
- Priorities and exclusions:
  - off_evt beats everything.
  - on_evt and off_evt in the same cycle while in OFF -> no pulse, stay OFF.
  - on_evt outside OFF is ignored.
  - Events are not queued; an event ignored in its cycle is lost.
- Outputs:
  - At most one cmd_* is high per cycle (one-hot or zero).
  - Each pulse is exactly one cycle wide.
  - Consecutive mode commands are at least MIN_DWELL+1 edges apart, except cmd_off.

Test Plan:
1. Reset, btn_on=1 for 3 cycles then 0 -> no pulse, mode=00. btn_on=1 held -> level flips on 4th edge, cmd_on high for exactly 1 cycle on the next cycle, mode=01.
2. In IDLE with setpoint=22, temp_valid pulse with temp=18 -> cmd_heat asserted exactly MIN_DWELL+1=9 edges after the cmd_on edge, mode=10. Repeat with temp=20 -> no pulse, stays IDLE (band edge).
3. In HEAT with setpoint=22: temp=24 -> no pulse. temp=25 -> cmd_cool only once dwell=0, mode=11. Overflow case: setpoint=254, temp=255 -> no cmd_cool.
4. In COOL, 3 cycles after cmd_cool (dwell nonzero), btn_off debounced -> cmd_off the next cycle, mode=00, dwell reloaded. A later temp change produces no pulse.
5. btn_on and btn_off raw rise together: in OFF -> no pulse, mode=00. In COOL -> cmd_off only. Check across all runs that cmd_* is never more than one-hot.
6. Reset asserted asynchronously mid-cycle in HEAT during a cmd_cool pulse -> all cmd_*=0 and mode=00 before the next clk edge. After release, no pulse until a new debounced btn_on.
